// File: rtl/fsm_timer_prog.sv
// Programmable period timer: one-shot or auto-reload, with hold, acknowledge
// handshake and a sticky overrun flag for auto-reload events that were lost.
module fsm_timer_prog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic             MODE,
  input  logic             HOLD,
  input  logic             ACK,
  output logic             READY,
  output logic             BUSY,
  output logic [WIDTH-1:0] COUNT,
  output logic             OVERRUN
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic [WIDTH-1:0] r_count;
  logic             r_ready;
  logic             r_busy;
  logic             r_overrun;

  logic [WIDTH-1:0] w_period_eff;
  logic             w_terminal;

  // A zero period would never terminate, so it runs as a single-cycle period
  assign w_period_eff = (PERIOD == '0) ? WIDTH'(1) : PERIOD;
  assign w_terminal   = (r_count == (r_period - WIDTH'(1)));

  // State machine with registered outputs; sync abort overrides everything
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_state   <= S_IDLE;
      r_period  <= WIDTH'(1);
      r_mode    <= 1'b0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (RESET) begin
      r_state   <= S_IDLE;
      r_period  <= WIDTH'(1);
      r_mode    <= 1'b0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (START) begin
            r_period  <= w_period_eff;
            r_mode    <= MODE;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!HOLD) begin
            if (w_terminal) begin
              r_ready <= 1'b1;
              if (r_mode) begin
                // Expiry while the previous one is still unacknowledged is lost
                if (r_ready && !ACK) begin
                  r_overrun <= 1'b1;
                end
                r_count <= '0;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end
            end else begin
              r_count <= r_count + WIDTH'(1);
              if (ACK) begin
                r_ready <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          if (ACK) begin
            r_ready <= 1'b0;
            r_count <= '0;
            if (START) begin
              r_period  <= w_period_eff;
              r_mode    <= MODE;
              r_overrun <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign READY   = r_ready;
  assign BUSY    = r_busy;
  assign COUNT   = r_count;
  assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_fsm_timer_prog.sv
// Bench for fsm_timer_prog: directed scenarios then random traffic, each edge
// checked against a cycles-remaining model of the timer.
module tb_fsm_timer_prog;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         N_RESET;
  logic         RESET;
  logic         START;
  logic [W-1:0] PERIOD;
  logic         MODE;
  logic         HOLD;
  logic         ACK;
  logic         READY;
  logic         BUSY;
  logic [W-1:0] COUNT;
  logic         OVERRUN;

  fsm_timer_prog #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .RESET   (RESET),
    .START   (START),
    .PERIOD  (PERIOD),
    .MODE    (MODE),
    .HOLD    (HOLD),
    .ACK     (ACK),
    .READY   (READY),
    .BUSY    (BUSY),
    .COUNT   (COUNT),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase, latched period, cycles remaining until expiry, flags
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;
  int m_phase;
  int m_p;
  int m_left;
  bit m_auto;
  bit m_ready;
  bit m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_p     = 1;
    m_left  = 0;
    m_auto  = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_begin();
    m_p     = (PERIOD == 0) ? 1 : int'(PERIOD);
    m_left  = m_p;
    m_auto  = MODE;
    m_phase = PH_RUN;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock edge of the timer behaviour given the currently driven inputs
  task automatic model_edge();
    if (!N_RESET || RESET) begin
      model_reset();
    end else if (m_phase == PH_IDLE) begin
      if (START) model_begin();
    end else if (m_phase == PH_DONE) begin
      if (ACK) begin
        m_ready = 1'b0;
        m_phase = PH_IDLE;
        if (START) model_begin();
      end
    end else if (!HOLD) begin
      if (m_left == 1) begin
        if (m_auto) begin
          if (m_ready && !ACK) m_ovr = 1'b1;
          m_left = m_p;
        end else begin
          m_phase = PH_DONE;
        end
        m_ready = 1'b1;
      end else begin
        m_left--;
        if (ACK) m_ready = 1'b0;
      end
    end
  endtask

  function automatic int exp_count();
    if (m_phase == PH_RUN)  return m_p - m_left;
    if (m_phase == PH_DONE) return m_p - 1;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".READY"},   32'(READY),   32'(m_ready));
    check({tag, ".BUSY"},    32'(BUSY),    32'(m_phase == PH_RUN));
    check({tag, ".COUNT"},   32'(COUNT),   32'(exp_count()));
    check({tag, ".OVERRUN"}, 32'(OVERRUN), 32'(m_ovr));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    START = 1'b0; ACK = 1'b0; HOLD = 1'b0; RESET = 1'b0;
  endtask

  initial begin
    N_RESET = 1'b0; RESET = 1'b0; START = 1'b0; PERIOD = '0;
    MODE = 1'b0; HOLD = 1'b0; ACK = 1'b0;
    model_reset();
    #2;
    check_all("por");
    step("por_clk");
    N_RESET = 1'b1;
    step("idle");

    // One-shot, period 5, ACK a few cycles after expiry
    PERIOD = 8'd5; MODE = 1'b0; START = 1'b1;
    step("os_start");
    check("os_start_busy", 32'(BUSY), 32'd1);
    START = 1'b0;
    repeat (4) step("os_run");
    check("os_count4", 32'(COUNT), 32'd4);
    check("os_not_ready", 32'(READY), 32'd0);
    step("os_term");
    check("os_ready", 32'(READY), 32'd1);
    check("os_done_busy", 32'(BUSY), 32'd0);
    START = 1'b1;
    step("os_done_start_ignored");
    START = 1'b0;
    step("os_done");
    ACK = 1'b1;
    step("os_ack");
    ACK = 1'b0;
    check("os_ack_ready", 32'(READY), 32'd0);

    // Hold for three cycles in the middle of a period-4 run
    PERIOD = 8'd4; START = 1'b1;
    step("hold_start");
    START = 1'b0;
    step("hold_run");
    HOLD = 1'b1;
    repeat (3) step("hold_frozen");
    check("hold_count", 32'(COUNT), 32'd1);
    HOLD = 1'b0;
    repeat (2) step("hold_resume");
    check("hold_not_ready", 32'(READY), 32'd0);
    step("hold_term");
    check("hold_ready", 32'(READY), 32'd1);
    ACK = 1'b1;
    step("hold_ack");
    ACK = 1'b0;

    // Auto-reload period 3 with no ACK: overrun on the second expiry
    PERIOD = 8'd3; MODE = 1'b1; START = 1'b1;
    step("ar_start");
    START = 1'b0;
    repeat (2) step("ar_run");
    step("ar_term1");
    check("ar_ready1", 32'(READY), 32'd1);
    check("ar_ovr1", 32'(OVERRUN), 32'd0);
    START = 1'b1;
    repeat (2) step("ar_run2_start_ignored");
    START = 1'b0;
    step("ar_term2");
    check("ar_ovr2", 32'(OVERRUN), 32'd1);
    check("ar_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    step("ar_reset");
    RESET = 1'b0;
    check("ar_reset_ovr", 32'(OVERRUN), 32'd0);

    // Auto-reload with ACK exactly on the second terminal edge
    START = 1'b1;
    step("arack_start");
    START = 1'b0;
    repeat (3) step("arack_run1");
    repeat (2) step("arack_run2");
    ACK = 1'b1;
    step("arack_term");
    ACK = 1'b0;
    check("arack_ready", 32'(READY), 32'd1);
    check("arack_ovr", 32'(OVERRUN), 32'd0);
    ACK = 1'b1;
    step("arack_clear");
    ACK = 1'b0;
    check("arack_cleared", 32'(READY), 32'd0);
    RESET = 1'b1;
    step("arack_reset");
    RESET = 1'b0;

    // One-shot reaches DONE, then ACK+START restarts with period 2
    PERIOD = 8'd3; MODE = 1'b0; START = 1'b1;
    step("rs_start");
    START = 1'b0;
    repeat (3) step("rs_run");
    ACK = 1'b1; START = 1'b1; PERIOD = 8'd2;
    step("rs_restart");
    check("rs_busy", 32'(BUSY), 32'd1);
    check("rs_ready0", 32'(READY), 32'd0);
    ACK = 1'b0; START = 1'b0;
    repeat (2) step("rs_run2");
    check("rs_ready1", 32'(READY), 32'd1);
    ACK = 1'b1;
    step("rs_ack");
    ACK = 1'b0;

    // Period 0 behaves as period 1
    PERIOD = 8'd0; START = 1'b1;
    step("p0_start");
    START = 1'b0;
    step("p0_term");
    check("p0_ready", 32'(READY), 32'd1);
    ACK = 1'b1;
    step("p0_ack");
    ACK = 1'b0;

    // Maximum period 255
    PERIOD = 8'd255; START = 1'b1;
    step("pmax_start");
    START = 1'b0;
    repeat (254) step("pmax_run");
    check("pmax_count", 32'(COUNT), 32'd254);
    check("pmax_not_ready", 32'(READY), 32'd0);
    step("pmax_term");
    check("pmax_ready", 32'(READY), 32'd1);
    check("pmax_hold_count", 32'(COUNT), 32'd254);
    ACK = 1'b1;
    step("pmax_ack");
    ACK = 1'b0;

    // Asynchronous reset while COUNT is 2
    PERIOD = 8'd5; START = 1'b1;
    step("ar_async_start");
    START = 1'b0;
    repeat (2) step("ar_async_run");
    #2;
    N_RESET = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step("async_rst_held");
    N_RESET = 1'b1;

    // Synchronous abort on the terminal edge
    PERIOD = 8'd2; START = 1'b1;
    step("sr_start");
    START = 1'b0;
    step("sr_run");
    RESET = 1'b1;
    step("sr_term");
    RESET = 1'b0;
    check("sr_ready", 32'(READY), 32'd0);
    check("sr_busy", 32'(BUSY), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      START  = ($urandom_range(0, 99) < 30);
      ACK    = ($urandom_range(0, 99) < 20);
      HOLD   = ($urandom_range(0, 99) < 15);
      RESET  = ($urandom_range(0, 99) < 2);
      MODE   = $urandom_range(0, 1) == 1;
      PERIOD = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      step("rand");
    end
    idle_inputs();
    step("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_timer_prog.md
FSM_TIMER_PROG -- requirements
Module: fsm_timer_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter and PERIOD width in bits (WIDTH >= 2).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port N_RESET  input  1  asynchronous active-low reset.
REQ-004 SHALL have port RESET  input  1  synchronous abort, active-high.
REQ-005 SHALL have port START  input  1  request to begin timing.
REQ-006 SHALL have port PERIOD  input  WIDTH  terminal period in cycles, sampled only when START is accepted.
REQ-007 SHALL have port MODE  input  1  0 = one-shot, 1 = auto-reload; sampled only when START is accepted.
REQ-008 SHALL have port HOLD  input  1  pauses counting while high.
REQ-009 SHALL have port ACK  input  1  acknowledges and clears READY.
REQ-010 SHALL have port READY  output  1  timer-expired flag, held until acknowledged.
REQ-011 SHALL have port BUSY  output  1  high while counting (state RUN).
REQ-012 SHALL have port COUNT  output  WIDTH  current count value.
REQ-013 SHALL have port OVERRUN  output  1  sticky flag: auto-reload expiry lost because READY was still pending.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; BUSY = (state == RUN), registered or decoded from state only.
REQ-015 SHALL treat latched period P = PERIOD, except PERIOD = 0 is treated as P = 1.
REQ-016 IDLE: START=1 at edge k latches P and MODE, COUNT <= 0, state <= RUN; START=0 stays IDLE, COUNT held at 0.
REQ-017 RUN, HOLD=0: COUNT increments by 1 per edge; terminal edge is the one where COUNT == P-1.
REQ-018 RUN, HOLD=1: COUNT, state and READY frozen; terminal edge cannot occur while HOLD=1.
REQ-019 With HOLD=0 throughout, START accepted at edge k SHALL give READY=1 after edge k+P (P cycles of RUN).
REQ-020 One-shot terminal edge: state <= DONE, READY <= 1, COUNT <= P-1 (held).
REQ-021 DONE: READY held at 1 until ACK=1; ACK=1 -> state IDLE, READY 0, COUNT 0.
REQ-022 DONE with ACK=1 and START=1 on the same edge: SHALL restart directly to RUN with new PERIOD/MODE, READY 0.
REQ-023 DONE with START=1 and ACK=0: START ignored.
REQ-024 Auto-reload terminal edge: state stays RUN, COUNT <= 0, READY <= 1.
REQ-025 Auto-reload terminal edge while READY=1 and ACK=0: OVERRUN <= 1 (sticky), READY stays 1.
REQ-026 ACK=1 and auto-reload terminal on the same edge: READY stays 1 (new event), OVERRUN unchanged.
REQ-027 ACK=1 in RUN without terminal edge: READY <= 0; ACK in IDLE has no effect.
REQ-028 START in RUN SHALL be ignored (no retrigger); auto-reload runs until RESET.
REQ-029 OVERRUN SHALL clear only on RESET, N_RESET, or START accepted from IDLE/DONE.
REQ-030 COUNT arithmetic SHALL be unsigned WIDTH-bit; COUNT never exceeds P-1, so no wrap beyond terminal.

Reset
REQ-031 N_RESET=0 SHALL asynchronously force state IDLE, COUNT 0, READY 0, OVERRUN 0, BUSY 0.
REQ-032 RESET=1 SHALL synchronously force the same values at the next edge, overriding START, ACK, HOLD and any terminal event.
REQ-033 Reset released mid-operation SHALL always resume from IDLE; no stale P or MODE is used.

Verification
REQ-034 One-shot: PERIOD=5, MODE=0, START pulse at edge 0 -> BUSY edges 1-5, COUNT 0..4, READY=1 after edge 5; ACK at edge 8 -> IDLE, READY 0, COUNT 0.
REQ-035 Hold: PERIOD=4, HOLD=1 for 3 cycles mid-run -> READY after edge 7, COUNT frozen during HOLD.
REQ-036 Auto-reload/overrun: PERIOD=3, MODE=1, no ACK -> READY after edge 3, OVERRUN=1 after edge 6, COUNT sequence 0,1,2,0,1,2.
REQ-037 Simultaneous: auto-reload ACK on terminal edge -> READY stays 1, OVERRUN 0; DONE with ACK+START, PERIOD=2 -> RUN immediately, READY 0, READY again 2 edges later.
REQ-038 Boundaries: PERIOD=0 -> READY after 1 cycle; PERIOD=255 (WIDTH=8) -> READY after 255 cycles, COUNT max 254.
REQ-039 Reset mid-run: N_RESET low asynchronously at COUNT=2 -> all outputs 0 before next edge; RESET=1 coincident with terminal edge -> READY 0, IDLE.
